// File: rtl/keypad_scan_ctrl.sv
// keypad_scan_ctrl: column scanner, row synchronizer and shared press/release
// debounce for a 4x4 hex keypad. Emits one key_valid pulse per accepted press.
module keypad_scan_ctrl #(
  parameter int SCAN_DIV        = 1000,
  parameter int DEBOUNCE_CYCLES = 120000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held,
  output logic [1:0] state
);

  localparam int DW = $clog2(SCAN_DIV);
  localparam int BW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
  localparam logic [BW-1:0] DEB_LAST   = BW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_SCAN    = 2'd0,
    ST_CONFIRM = 2'd1,
    ST_HELD    = 2'd2,
    ST_RELEASE = 2'd3
  } state_e;

  state_e        state_q, state_d;
  logic [3:0]    row_meta_q, rs_q;
  logic [3:0]    col_q, col_d;
  logic [3:0]    lrow_q, lrow_d;
  logic [3:0]    lcol_q, lcol_d;
  logic [DW-1:0] dwell_q, dwell_d;
  logic [BW-1:0] deb_q, deb_d;
  logic [3:0]    key_code_q, key_code_d;
  logic          key_valid_q, key_valid_d;
  logic          key_held_q, key_held_d;

  // True when exactly one bit of v is set.
  function automatic logic is_onehot(input logic [3:0] v);
    return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
  endfunction

  // Position of the set bit in a one-hot nibble.
  function automatic logic [1:0] onehot_idx(input logic [3:0] v);
    logic [1:0] idx;
    case (v)
      4'b0001: idx = 2'd0;
      4'b0010: idx = 2'd1;
      4'b0100: idx = 2'd2;
      4'b1000: idx = 2'd3;
      default: idx = 2'd0;
    endcase
    return idx;
  endfunction

  // Next column in the sweep: left-rotate, 1000 wraps to 0001.
  function automatic logic [3:0] rotl(input logic [3:0] c);
    return {c[2:0], c[3]};
  endfunction

  // Hex legend of the key at (row, col), row 0 top, col 0 left.
  function automatic logic [3:0] key_map(input logic [1:0] r, input logic [1:0] c);
    logic [3:0] k;
    case ({r, c})
      4'h0: k = 4'h1;  4'h1: k = 4'h2;  4'h2: k = 4'h3;  4'h3: k = 4'hA;
      4'h4: k = 4'h4;  4'h5: k = 4'h5;  4'h6: k = 4'h6;  4'h7: k = 4'hB;
      4'h8: k = 4'h7;  4'h9: k = 4'h8;  4'hA: k = 4'h9;  4'hB: k = 4'hC;
      4'hC: k = 4'hE;  4'hD: k = 4'h0;  4'hE: k = 4'hF;  4'hF: k = 4'hD;
      default: k = 4'h0;
    endcase
    return k;
  endfunction

  // Two-flop synchronizer for the asynchronous row pins.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      row_meta_q <= 4'd0;
      rs_q       <= 4'd0;
    end else begin
      row_meta_q <= row;
      rs_q       <= row_meta_q;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_SCAN;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state, column drive, latched key, shared timer and output pulse.
  always_comb begin
    state_d     = state_q;
    col_d       = col_q;
    lrow_d      = lrow_q;
    lcol_d      = lcol_q;
    dwell_d     = dwell_q;
    deb_d       = deb_q;
    key_code_d  = key_code_q;
    key_valid_d = 1'b0;
    case (state_q)
      ST_SCAN: begin
        if (dwell_q == DWELL_LAST) begin
          dwell_d = '0;
          if (is_onehot(rs_q)) begin
            // Freeze the column on the candidate key and start debouncing.
            lrow_d  = rs_q;
            lcol_d  = col_q;
            deb_d   = '0;
            state_d = ST_CONFIRM;
          end else begin
            col_d = rotl(col_q);
          end
        end else begin
          dwell_d = dwell_q + DW'(1);
        end
      end
      ST_CONFIRM: begin
        col_d = lcol_q;
        // A changed row aborts even on the terminal count.
        if (rs_q != lrow_q) begin
          state_d = ST_SCAN;
          dwell_d = '0;
          col_d   = rotl(lcol_q);
        end else if (deb_q == DEB_LAST) begin
          state_d     = ST_HELD;
          key_code_d  = key_map(onehot_idx(lrow_q), onehot_idx(lcol_q));
          key_valid_d = 1'b1;
        end else begin
          deb_d = deb_q + BW'(1);
        end
      end
      ST_HELD: begin
        col_d = lcol_q;
        // Only the latched row matters here; other keys give no rollover.
        if ((rs_q & lrow_q) == 4'd0) begin
          deb_d   = '0;
          state_d = ST_RELEASE;
        end else begin
          deb_d = deb_q;
        end
      end
      ST_RELEASE: begin
        col_d = lcol_q;
        // A re-press wins over the terminal count.
        if ((rs_q & lrow_q) != 4'd0) begin
          state_d = ST_HELD;
          deb_d   = '0;
        end else if (deb_q == DEB_LAST) begin
          state_d = ST_SCAN;
          dwell_d = '0;
          col_d   = rotl(lcol_q);
        end else begin
          deb_d = deb_q + BW'(1);
        end
      end
      default: begin
        state_d = ST_SCAN;
        col_d   = 4'b0001;
        dwell_d = '0;
      end
    endcase
    key_held_d = (state_d == ST_HELD) || (state_d == ST_RELEASE);
  end

  // Datapath and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      col_q       <= 4'b0001;
      lrow_q      <= 4'd0;
      lcol_q      <= 4'd0;
      dwell_q     <= '0;
      deb_q       <= '0;
      key_code_q  <= 4'd0;
      key_valid_q <= 1'b0;
      key_held_q  <= 1'b0;
    end else begin
      col_q       <= col_d;
      lrow_q      <= lrow_d;
      lcol_q      <= lcol_d;
      dwell_q     <= dwell_d;
      deb_q       <= deb_d;
      key_code_q  <= key_code_d;
      key_valid_q <= key_valid_d;
      key_held_q  <= key_held_d;
    end
  end

  assign col       = col_q;
  assign key_code  = key_code_q;
  assign key_valid = key_valid_q;
  assign key_held  = key_held_q;
  assign state     = state_q;

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Bench for keypad_scan_ctrl: a keypad model drives the rows from the pressed
// key set and the driven column; a cycle-level reference predicts every output.
module tb_keypad_scan_ctrl;
  localparam int SD = 4;
  localparam int DB = 8;
  localparam int P_SCAN = 0, P_CONFIRM = 1, P_HELD = 2, P_RELEASE = 3;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] row;
  logic [3:0] col, key_code;
  logic       key_valid, key_held;
  logic [1:0] state;

  keypad_scan_ctrl #(.SCAN_DIV(SD), .DEBOUNCE_CYCLES(DB)) dut (
    .clk(clk), .reset(reset), .row(row), .col(col), .key_code(key_code),
    .key_valid(key_valid), .key_held(key_held), .state(state)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int pulses = 0;
  int n_confirm = 0;
  logic [15:0] pressed;  // bit r*4+c = key at row r, column c is down

  // Reference model state (integer indices, not one-hot)
  int m_phase, m_dwell, m_timer, m_col, m_lrow, m_lcol, m_code, m_valid;
  logic [3:0] m_meta, m_rs;
  int keymap [16] = '{1, 2, 3, 10, 4, 5, 6, 11, 7, 8, 9, 12, 14, 0, 15, 13};

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [3:0] kp_rows(input logic [15:0] p, input logic [3:0] c);
    logic [3:0] r;
    r = 4'd0;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        if (p[i*4+j] && c[j]) r[i] = 1'b1;
    return r;
  endfunction

  task automatic model_reset();
    m_phase = P_SCAN; m_dwell = 0; m_timer = 0; m_col = 0;
    m_lrow = 0; m_lcol = 0; m_code = 0; m_valid = 0;
    m_meta = 4'd0; m_rs = 4'd0;
  endtask

  task automatic back_to_scan();
    m_phase = P_SCAN; m_dwell = 0; m_col = (m_lcol + 1) % 4;
  endtask

  task automatic model_step(input logic [3:0] r_in);
    logic [3:0] lmask;
    lmask = 4'd1 << m_lrow;
    m_valid = 0;
    case (m_phase)
      P_SCAN: begin
        if (m_dwell == SD - 1) begin
          m_dwell = 0;
          if ($countones(m_rs) == 1) begin
            for (int i = 0; i < 4; i++) if (m_rs[i]) m_lrow = i;
            m_lcol = m_col; m_timer = 0; m_phase = P_CONFIRM;
          end else m_col = (m_col + 1) % 4;
        end else m_dwell++;
      end
      P_CONFIRM: begin
        if (m_rs != lmask) back_to_scan();
        else if (m_timer == DB - 1) begin
          m_phase = P_HELD; m_code = keymap[m_lrow*4 + m_lcol]; m_valid = 1;
        end else m_timer++;
      end
      P_HELD: begin
        if ((m_rs & lmask) == 4'd0) begin m_timer = 0; m_phase = P_RELEASE; end
      end
      default: begin
        if ((m_rs & lmask) != 4'd0) begin m_phase = P_HELD; m_timer = 0; end
        else if (m_timer == DB - 1) back_to_scan();
        else m_timer++;
      end
    endcase
    m_rs = m_meta;
    m_meta = r_in;
  endtask

  task automatic compare_all();
    check_eq("col", col, 1 << m_col);
    check_eq("state", state, m_phase);
    check_eq("key_valid", key_valid, m_valid);
    check_eq("key_code", key_code, m_code);
    check_eq("key_held", key_held, (m_phase == P_HELD || m_phase == P_RELEASE) ? 1 : 0);
  endtask

  // One clock: present rows, let the edge happen, advance the model, compare.
  task automatic step();
    row = kp_rows(pressed, col);
    @(posedge clk);
    model_step(row);
    #1;
    if (key_valid) pulses++;
    if (state == 2'd1) n_confirm++;
    compare_all();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic wait_phase(input int ph, input int budget, input string tag);
    int k;
    k = 0;
    while (m_phase != ph && k < budget) begin step(); k++; end
    check_eq(tag, state, ph);
  endtask

  function automatic logic [15:0] key_bit(input int idx);
    logic [15:0] b;
    b = 16'd1 << idx;
    return b;
  endfunction

  initial begin
    int k, c;
    reset = 1'b1; row = 4'd0; pressed = 16'd0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_col", col, 1);
    check_eq("rst_state", state, 0);
    check_eq("rst_valid", key_valid, 0);
    check_eq("rst_code", key_code, 0);
    check_eq("rst_held", key_held, 0);
    @(negedge clk) reset = 1'b0;

    // Idle sweep: col rotates every SD cycles and wraps.
    run(4);  check_eq("idle_col4", col, 2);
    run(8);  check_eq("idle_col12", col, 8);
    run(4);  check_eq("idle_col16", col, 1);
    run(8);

    // Key '5' (row1, col1): one pulse, code 5, resume at col2 after release.
    pulses = 0;
    pressed = key_bit(5);
    wait_phase(P_CONFIRM, 40, "b_confirm");
    check_eq("b_col_frozen", col, 2);
    wait_phase(P_HELD, 20, "b_held");
    check_eq("b_code", key_code, 5);
    run(10);
    pressed = 16'd0;
    wait_phase(P_RELEASE, 10, "b_release");
    wait_phase(P_SCAN, 20, "b_scan");
    check_eq("b_col_resume", col, 4);
    check_eq("b_pulses", pulses, 1);
    run(10);

    // Bounce: release 3 cycles into CONFIRM, expect abort with no pulse.
    pulses = 0;
    k = $urandom_range(0, 15);
    pressed = key_bit(k);
    wait_phase(P_CONFIRM, 40, "c_confirm");
    run(2);
    pressed = 16'd0;
    run(20);
    check_eq("c_pulses", pulses, 0);
    check_eq("c_code", key_code, 5);

    // Multi-hot: two rows in the same column never start a CONFIRM.
    pulses = 0; n_confirm = 0;
    c = $urandom_range(0, 3);
    pressed = key_bit(c) | key_bit(8 + c);
    run(40);
    check_eq("d_confirms", n_confirm, 0);
    check_eq("d_pulses", pulses, 0);
    pressed = 16'd0;
    run(8);

    // Second key while held: '6' is ignored until '5' is released.
    pulses = 0;
    pressed = key_bit(5);
    wait_phase(P_HELD, 60, "e_held5");
    check_eq("e_code5", key_code, 5);
    pressed = pressed | key_bit(6);
    run(12);
    pressed = key_bit(6);
    wait_phase(P_RELEASE, 10, "e_release");
    wait_phase(P_SCAN, 20, "e_scan");
    wait_phase(P_HELD, 60, "e_held6");
    check_eq("e_code6", key_code, 6);
    check_eq("e_pulses", pulses, 2);
    pressed = 16'd0;
    run(30);

    // Release glitch: one-cycle re-press in RELEASE returns to HELD, no pulse.
    k = $urandom_range(0, 15);
    pressed = key_bit(k);
    wait_phase(P_HELD, 60, "f_held");
    pulses = 0;
    pressed = 16'd0;
    wait_phase(P_RELEASE, 10, "f_release");
    run(2);
    pressed = key_bit(k);
    step();
    pressed = 16'd0;
    run(30);
    check_eq("f_pulses", pulses, 0);

    // Reset during CONFIRM: outputs return to reset values without a clock.
    k = $urandom_range(0, 15);
    pressed = key_bit(k);
    wait_phase(P_CONFIRM, 60, "g_confirm");
    run(2);
    #3 reset = 1'b1;
    pressed = 16'd0; row = 4'd0;
    #1;
    check_eq("g_col", col, 1);
    check_eq("g_state", state, 0);
    check_eq("g_valid", key_valid, 0);
    check_eq("g_held", key_held, 0);
    check_eq("g_code", key_code, 0);
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 1'b0;
    pulses = 0;
    run(30);
    check_eq("g_nopulse", pulses, 0);

    // Random episodes of zero, one or two keys for random durations.
    for (int e = 0; e < 30; e++) begin
      case ($urandom_range(0, 2))
        0: pressed = 16'd0;
        1: pressed = key_bit($urandom_range(0, 15));
        default: pressed = key_bit($urandom_range(0, 15)) | key_bit($urandom_range(0, 15));
      endcase
      run($urandom_range(1, 40));
    end
    pressed = 16'd0;
    run(40);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
